// File: rtl/ofm_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ofm_drain                                                  |
// | Description : Drain stage at the bottom of a systolic column. It         |
// |               captures the final partial sum on mac_done into a small    |
// |               first-word-fall-through FIFO. The FIFO presents results as |
// |               a valid/ready stream. Results dropped because the FIFO was |
// |               full are flagged (sticky ovf) and counted (saturating).    |
// |               Optional build macro OFM_RELU_EN clamps negative results   |
// |               to zero at capture.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ofm_drain #(
   parameter int OWIDTH = 16,
   parameter int DEPTH  = 4,
   parameter int CWIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_o,
   input  logic                       clr_o,
   input  logic                       mac_done,
   input  logic signed [OWIDTH-1:0]   ofm,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic signed [OWIDTH-1:0]   o_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       ovf,
   output logic [CWIDTH-1:0]          drop_cnt
);

   localparam int C_PW = $clog2(DEPTH);
   localparam int C_CW = $clog2(DEPTH+1);
   localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

   logic [OWIDTH-1:0] r_mem [DEPTH];
   logic [C_PW-1:0]   r_wr_ptr;
   logic [C_PW-1:0]   r_rd_ptr;
   logic [C_CW-1:0]   r_count;
   logic              r_ovf;
   logic [CWIDTH-1:0] r_drop_cnt;

   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_wr_en;
   logic              w_drop;
   logic [OWIDTH-1:0] w_wdata;

   assign w_push = mac_done & en_o;
   assign w_pop  = (r_count != '0) & o_ready;
   assign w_full = (r_count == C_FULL);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign w_wr_en = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

`ifdef OFM_RELU_EN
   assign w_wdata = ofm[OWIDTH-1] ? '0 : ofm;
`else
   assign w_wdata = ofm;
`endif

   // Storage array: written at the write pointer on an accepted push
   always_ff @(posedge clk) begin
      if (w_wr_en && !clr_o) begin
         r_mem[r_wr_ptr] <= w_wdata;
      end
   end

   // Pointer and occupancy bookkeeping; clear overrides push and pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr_o) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + C_PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PW'(1);
         end
         if (w_wr_en && !w_pop) begin
            r_count <= r_count + C_CW'(1);
         end else if (!w_wr_en && w_pop) begin
            r_count <= r_count - C_CW'(1);
         end
      end
   end

   // Overflow flag and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (clr_o) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
         if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + CWIDTH'(1);
         end
      end
   end

   // Head of FIFO is driven straight from storage; zero when empty
   assign o_valid  = (r_count != '0);
   assign o_data   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign count    = r_count;
   assign ovf      = r_ovf;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/ofm_drain.md
Name: ofm_drain

Overview:
- Reader end of a systolic column's partial-sum chain.
- Sits below the last PE of each column. It samples the final accumulated ofm when the column's mac_done arrives.
- Buffers results in a small FWFT FIFO and hands them to the output writeback as a valid/ready stream.
- Flags and counts results lost to backpressure.

Parameters:
- OWIDTH, 16, width of the signed accumulated output word.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CWIDTH, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_o  input  1  output-enable travelling with the column; capture is qualified by it.
- clr_o  input  1  synchronous flush of FIFO, overflow flag and drop counter.
- mac_done  input  1  one-cycle pulse from the last PE: ofm is final this cycle.
- ofm  input  OWIDTH  signed accumulated result from the last PE.
- o_valid  output  1  head entry is valid.
- o_ready  input  1  downstream accepts head this cycle.
- o_data  output  OWIDTH  signed head entry.
- count  output  $clog2(DEPTH+1)  current occupancy.
- ovf  output  1  sticky: at least one result was dropped.
- drop_cnt  output  CWIDTH  number of dropped results, saturating at all-ones.

Behaviour:
- Reset (rst=1, asynchronous): FIFO empty, rd/wr pointers 0, count=0, o_valid=0, o_data=0, ovf=0, drop_cnt=0. Reset asserted mid-stream discards all entries immediately.
- push = mac_done & en_o. pop = o_valid & o_ready.
- Push writes ofm, post optional-feature transform, at the write pointer. The entry is visible at o_data/o_valid the next cycle.
- Capture latency is 1 cycle. There is no combinational path from ofm or mac_done to the outputs.
- FWFT: o_data = entry at read pointer when count>0, else 0. o_valid = (count!=0).
- o_data is held stable while o_valid=1 and o_ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is the full-width occupancy.
- Push and pop in the same cycle, count unchanged:
  - 0<count<DEPTH: both take effect.
  - count==DEPTH: pop frees the slot and the push is accepted; no drop.
  - count==0: pop is impossible because o_valid=0; the push is accepted.
- Push while count==DEPTH and no pop: the result is discarded, ovf<=1, and drop_cnt increments unless it is already all-ones.
- o_ready with o_valid=0 has no effect.
- clr_o=1: next cycle count=0, pointers=0, ovf=0, drop_cnt=0. clr_o has priority over push and pop in the same cycle, so a simultaneous push is discarded and not counted as a drop.
- en_o=0 gates capture only. Pops continue regardless of en_o.
- mac_done high on consecutive cycles produces one push per cycle.

Optional Feature:
- Macro: OFM_RELU_EN.
- Defined: at push, negative ofm (MSB=1) is stored as 0 and non-negative values are stored unchanged. ovf and drop accounting are unaffected.
- Undefined: ofm is stored verbatim as signed OWIDTH. No extra logic is instantiated.

Test Plan:
1. Reset then single capture: rst pulse; en_o=1, mac_done pulse with ofm=16'sh0123, o_ready=0 -> next cycle o_valid=1, o_data=16'h0123, count=1. Raise o_ready -> following cycle o_valid=0, count=0.
2. Fill and drop: o_ready=0, DEPTH=4; push -5,7,100,-32768, then 3 more pushes -> count=4, o_data=-5 held, ovf=1, drop_cnt=3. Drain yields exactly -5,7,100,-32768.
3. Full simultaneous push/pop: count=4 with head=1; push 9 while o_ready=1 -> count stays 4, ovf stays 0. Drain order is the remaining 3 entries, then 9.
4. Gating and clear: mac_done=1 with en_o=0 -> no push. Assert clr_o together with a push when count=2, ovf=1 -> next cycle count=0, ovf=0, drop_cnt=0, o_valid=0.
5. Async reset mid-stream: count=3, assert rst between edges -> o_valid, count, ovf fall immediately without a clock edge. After release, the first push appears alone.
6. OFM_RELU_EN: push -1 then 42 -> defined: o_data 0 then 42; undefined: 16'hFFFF then 42.
